// File: rtl/booth_product_accumulator_if.sv
// Bus between the operand issuer / result consumer and the product accumulator.
// The master side issues operands, feeds the multiplier's product and takes results.
// The slave side is the accumulator itself.
interface booth_product_accumulator_if #(
    parameter int OUT_W = 64,
    parameter int CNT_W = 16
);
    logic             OP_VALID;
    logic             OP_LAST;
    logic             OP_READY;
    logic [63:0]      Z_IN;
    logic [OUT_W-1:0] RES_DATA;
    logic             RES_OVF;
    logic [CNT_W-1:0] RES_COUNT;
    logic             RES_VALID;
    logic             RES_READY;
    logic             BUSY;

    modport master (
        output OP_VALID, OP_LAST, Z_IN, RES_READY,
        input  OP_READY, RES_DATA, RES_OVF, RES_COUNT, RES_VALID, BUSY
    );

    modport slave (
        input  OP_VALID, OP_LAST, Z_IN, RES_READY,
        output OP_READY, RES_DATA, RES_OVF, RES_COUNT, RES_VALID, BUSY
    );
endinterface

// File: rtl/booth_product_accumulator.sv
// Frame accumulator placed after the fixed-latency 32x32 signed Booth multiplier.
// A valid/last shadow pipe follows each accepted operand pair through the multiplier,
// so the matching product is summed exactly when it reaches Z_IN. The multiplier
// cannot stall, so back-pressure is applied on the operand side via OP_READY.
module booth_product_accumulator #(
    parameter int MUL_LAT = 2,
    parameter int ACC_W   = 80,
    parameter int OUT_W   = 64,
    parameter int CNT_W   = 16
) (
    input  logic                         CLK,
    input  logic                         RESET,
    booth_product_accumulator_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [MUL_LAT-1:0]      r_vpipe;
    logic [MUL_LAT-1:0]      r_lpipe;
    logic [MUL_LAT-1:0]      w_vpipe_next;
    logic [MUL_LAT-1:0]      w_lpipe_next;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_z_ext;
    logic signed [ACC_W-1:0] w_acc_add;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_inc;
    logic [OUT_W-1:0]        r_res_data;
    logic                    r_res_ovf;
    logic [CNT_W-1:0]        r_res_count;
    logic                    r_res_valid;
    logic [OUT_W-1:0]        w_sat_data;
    logic                    w_sat_ovf;
    logic                    w_op_ready;
    logic                    w_accept;
    logic                    w_product_here;
    logic                    w_last_here;
    logic                    w_res_take;
    logic                    w_frame_done;

    // Operands are only taken while a frame is open; DRAIN and OUT hold them off.
    assign w_op_ready     = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_accept       = bus.OP_VALID & w_op_ready;
    assign w_product_here = r_vpipe[MUL_LAT-1];
    assign w_last_here    = r_lpipe[MUL_LAT-1];
    assign w_res_take     = (r_state == S_OUT) & bus.RES_READY;
    assign w_frame_done   = (r_state == S_DRAIN) & w_product_here & w_last_here;

    // Product is sign-extended into the guarded accumulator; the sum wraps silently.
    assign w_z_ext     = ACC_W'($signed(bus.Z_IN));
    assign w_acc_add   = r_acc + w_z_ext;
    assign w_count_inc = (&r_count) ? r_count : r_count + 1'b1;

    // Shadow pipe tracking which multiplier outputs belong to accepted operands.
    assign w_vpipe_next[0] = w_accept;
    assign w_lpipe_next[0] = w_accept & bus.OP_LAST;
    generate
        for (genvar gi = 1; gi < MUL_LAT; gi++) begin : g_pipe
            assign w_vpipe_next[gi] = r_vpipe[gi-1];
            assign w_lpipe_next[gi] = r_lpipe[gi-1];
        end
    endgenerate

    // Clip the final sum to the signed OUT_W range; the upper bits must be a pure sign run.
    generate
        if (OUT_W < ACC_W) begin : g_clip
            logic [ACC_W-OUT_W:0] w_upper;
            logic                 w_fits;
            assign w_upper    = w_acc_add[ACC_W-1:OUT_W-1];
            assign w_fits     = (&w_upper) | ~(|w_upper);
            assign w_sat_ovf  = ~w_fits;
            assign w_sat_data = w_fits ? w_acc_add[OUT_W-1:0]
                              : (w_acc_add[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                    : {1'b0, {(OUT_W-1){1'b1}}});
        end else begin : g_noclip
            assign w_sat_ovf  = 1'b0;
            assign w_sat_data = w_acc_add[OUT_W-1:0];
        end
    endgenerate

    // Next-state selection; a single-product frame goes straight to DRAIN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = bus.OP_LAST ? S_DRAIN : S_ACCUM;
            S_ACCUM: if (w_accept && bus.OP_LAST) w_state_next = S_DRAIN;
            S_DRAIN: if (w_product_here && w_last_here) w_state_next = S_OUT;
            S_OUT:   if (bus.RES_READY) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register and shadow pipe; reset drops any products still in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_vpipe <= '0;
            r_lpipe <= '0;
        end else begin
            r_state <= w_state_next;
            r_vpipe <= w_vpipe_next;
            r_lpipe <= w_lpipe_next;
        end
    end

    // Running sum and product count, cleared when the result is taken.
    always_ff @(posedge CLK) begin
        if (RESET || w_res_take) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_product_here) begin
            r_acc   <= w_acc_add;
            r_count <= w_count_inc;
        end
    end

    // Result capture on the frame's last product, held until the consumer takes it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_res_data  <= '0;
            r_res_ovf   <= 1'b0;
            r_res_count <= '0;
            r_res_valid <= 1'b0;
        end else if (w_frame_done) begin
            r_res_data  <= w_sat_data;
            r_res_ovf   <= w_sat_ovf;
            r_res_count <= w_count_inc;
            r_res_valid <= 1'b1;
        end else if (w_res_take) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.OP_READY  = w_op_ready;
    assign bus.RES_DATA  = r_res_data;
    assign bus.RES_OVF   = r_res_ovf;
    assign bus.RES_COUNT = r_res_count;
    assign bus.RES_VALID = r_res_valid;
    assign bus.BUSY      = (r_state != S_IDLE) | (|r_vpipe);

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: a behavioural multiplier pipe feeds Z_IN,
// expected frame results go into a scoreboard queue as operands are issued and
// are compared when the DUT hands a result over.
module tb_booth_product_accumulator;
    localparam int MUL_LAT = 2;
    localparam int ACC_W   = 80;
    localparam int OUT_W   = 64;
    localparam int CNT_W   = 16;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    booth_product_accumulator_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    booth_product_accumulator #(
        .MUL_LAT (MUL_LAT),
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Multiplier stand-in: product of the operands presented at edge e reaches Z_IN
    // in time to be sampled at edge e+MUL_LAT.
    logic signed [31:0] op_a = 32'sd0;
    logic signed [31:0] op_b = 32'sd0;
    logic signed [63:0] zpipe [MUL_LAT];
    always @(posedge CLK) begin
        zpipe[0] <= op_a * op_b;
        for (int i = 1; i < MUL_LAT; i++) zpipe[i] <= zpipe[i-1];
    end
    assign bus.Z_IN = zpipe[MUL_LAT-1];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int last_accept_cyc = 0;

    typedef struct {
        logic [63:0] data;
        logic        ovf;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic signed [127:0] m_sum = '0;
    int                  m_cnt = 0;
    bit                  prev_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t make_exp(input logic signed [127:0] s, input int n);
        exp_t e;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< 63) - 128'sd1;
        lo = -(128'sd1 <<< 63);
        if (s > hi) begin
            e.data = hi[63:0];
            e.ovf  = 1'b1;
        end else if (s < lo) begin
            e.data = lo[63:0];
            e.ovf  = 1'b1;
        end else begin
            e.data = s[63:0];
            e.ovf  = 1'b0;
        end
        e.cnt = (n > 65535) ? 16'hFFFF : 16'(n);
        return e;
    endfunction

    // Issue one operand pair (called at a negedge); returns one negedge after the accept.
    task automatic push_op(input logic signed [31:0] a, input logic signed [31:0] b, input bit last);
        int guard;
        guard = 0;
        bus.OP_VALID = 1'b0;
        while (!bus.OP_READY && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        check("op_ready", {63'd0, bus.OP_READY}, 64'd1);
        op_a         = a;
        op_b         = b;
        bus.OP_LAST  = last;
        bus.OP_VALID = 1'b1;
        m_sum        = m_sum + a * b;
        m_cnt++;
        last_accept_cyc = cyc + 1;
        if (last) begin
            exp_q.push_back(make_exp(m_sum, m_cnt));
            m_sum = '0;
            m_cnt = 0;
        end
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        bus.OP_LAST  = 1'b0;
        op_a         = $urandom;
        op_b         = $urandom;
    endtask

    // A stray OP_LAST without OP_VALID, with junk operands into the multiplier.
    task automatic last_pulse();
        bus.OP_VALID = 1'b0;
        bus.OP_LAST  = 1'b1;
        op_a         = $urandom;
        op_b         = $urandom;
        @(negedge CLK);
        bus.OP_LAST  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.BUSY) && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_busy"}, {63'd0, bus.BUSY}, 64'd0);
        @(negedge CLK);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_op_ready"},  {63'd0, bus.OP_READY},  64'd1);
        check({tag, "_res_valid"}, {63'd0, bus.RES_VALID}, 64'd0);
        check({tag, "_res_data"},  bus.RES_DATA,           64'd0);
        check({tag, "_res_ovf"},   {63'd0, bus.RES_OVF},   64'd0);
        check({tag, "_res_count"}, 64'(bus.RES_COUNT),     64'd0);
        check({tag, "_busy"},      {63'd0, bus.BUSY},      64'd0);
    endtask

    // Result monitor: latency of RES_VALID and scoreboard comparison on each handshake.
    always @(negedge CLK) begin
        #2;
        if (RESET) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.RES_VALID && !prev_valid)
                check("latency", 64'(cyc - last_accept_cyc), 64'(MUL_LAT));
            if (bus.RES_VALID && bus.RES_READY) begin
                check("result_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("res_data",  bus.RES_DATA,           mon_e.data);
                    check("res_ovf",   {63'd0, bus.RES_OVF},   {63'd0, mon_e.ovf});
                    check("res_count", 64'(bus.RES_COUNT),     64'(mon_e.cnt));
                    $display("result data=0x%0h ovf=%0d count=%0d", bus.RES_DATA, bus.RES_OVF, bus.RES_COUNT);
                end
            end
            prev_valid = bus.RES_VALID;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus.OP_VALID  = 1'b0;
        bus.OP_LAST   = 1'b0;
        bus.RES_READY = 1'b1;
        RESET         = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        check_reset("reset");

        // Basic three-product frame at one accept per cycle: 12 - 30 + 49 = 31.
        push_op(32'sd3, 32'sd4, 1'b0);
        push_op(-32'sd5, 32'sd6, 1'b0);
        push_op(32'sd7, 32'sd7, 1'b1);
        wait_done("frame3");

        // Two products of 2^62 give 2^63, which clips to the positive limit.
        push_op(32'sh8000_0000, 32'sh8000_0000, 1'b0);
        push_op(32'sh8000_0000, 32'sh8000_0000, 1'b1);
        wait_done("overflow");

        // Single-product frame.
        push_op(-32'sd1, 32'sd1, 1'b1);
        wait_done("single");

        // Consumer stalls in OUT while upstream keeps OP_VALID high.
        bus.RES_READY = 1'b0;
        push_op(32'sd5, 32'sd5, 1'b0);
        push_op(32'sd6, 32'sd6, 1'b1);
        guard = 0;
        while (!bus.RES_VALID && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        check("stall_valid", {63'd0, bus.RES_VALID}, 64'd1);
        bus.OP_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_a        = $urandom;
            op_b        = $urandom;
            bus.OP_LAST = 1'($urandom);
            @(negedge CLK);
            check("stall_op_ready",  {63'd0, bus.OP_READY},  64'd0);
            check("stall_res_valid", {63'd0, bus.RES_VALID}, 64'd1);
            check("stall_res_data",  bus.RES_DATA,           64'd61);
            check("stall_res_count", 64'(bus.RES_COUNT),     64'd2);
        end
        bus.OP_VALID  = 1'b0;
        bus.OP_LAST   = 1'b0;
        bus.RES_READY = 1'b1;
        wait_done("stall");
        push_op(32'sd1, 32'sd1, 1'b0);
        push_op(32'sd2, 32'sd3, 1'b1);
        wait_done("after_stall");

        // Reset in the middle of a frame discards the products in flight.
        push_op(32'sd10, 32'sd10, 1'b0);
        push_op(32'sd20, 32'sd20, 1'b0);
        RESET = 1'b1;
        m_sum = '0;
        m_cnt = 0;
        @(negedge CLK);
        RESET = 1'b0;
        check_reset("mid_reset");
        push_op(32'sd2, 32'sd2, 1'b1);
        wait_done("post_reset");

        // OP_LAST pulses without OP_VALID between accepts: 9 + 16 + 2 = 27.
        push_op(32'sd3, 32'sd3, 1'b0);
        last_pulse();
        push_op(32'sd4, 32'sd4, 1'b0);
        last_pulse();
        last_pulse();
        push_op(32'sd1, 32'sd2, 1'b1);
        wait_done("last_pulse");

        // Longer back-to-back frame with random signed operands.
        for (int i = 0; i < 12; i++)
            push_op($urandom, $urandom, i == 11);
        wait_done("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
